// File: rtl/sub_share_pkg.sv
// Shared types and sizing helpers for the time-shared subtractor scheduler.
// Optional statistics are enabled by defining SUB_SHARE_STATS_EN.
package sub_share_pkg;

  localparam int STAT_W = 16;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  // Index width; a single requester still gets a 1-bit id.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping.
module rr_arbiter
  import sub_share_pkg::*;
#(
  parameter int N = 4,
  localparam int IW = id_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en && !any && req[(int'(ptr) + i) % N]) begin
        any                       = 1'b1;
        grant[(int'(ptr) + i) % N] = 1'b1;
        idx                       = IW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/sub_share_ctrl.sv
// One registered subtractor (a - b, DATA_W+1 bits) shared round-robin among N_REQ requesters.
// Define SUB_SHARE_STATS_EN to add saturating grant/stall counters.
module sub_share_ctrl
  import sub_share_pkg::*;
#(
  parameter int DATA_W = 24,
  parameter int N_REQ  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            i_req_valid,
  input  logic [N_REQ*DATA_W-1:0]     i_req_a,
  input  logic [N_REQ*DATA_W-1:0]     i_req_b,
  output logic [N_REQ-1:0]            o_req_ready,
  output logic [DATA_W:0]             o_c,
  output logic [id_w(N_REQ)-1:0]      o_id,
  output logic                        o_valid,
`ifdef SUB_SHARE_STATS_EN
  output logic [N_REQ*STAT_W-1:0]     o_grant_cnt,
  output logic [STAT_W-1:0]           o_stall_cnt,
`endif
  input  logic                        i_ready
);

  localparam int ID_W = id_w(N_REQ);

  out_state_t          state_reg;
  logic [ID_W-1:0]     ptr_reg;
  logic [ID_W-1:0]     gnt_idx;
  logic [N_REQ-1:0]    gnt;
  logic                gnt_any;
  logic                slot_free;
  logic [DATA_W-1:0]   a_sel;
  logic [DATA_W-1:0]   b_sel;
  logic [DATA_W:0]     diff;

  // Reset gates the arbiter so no handshake completes while the block is held.
  assign slot_free = (state_reg == ST_EMPTY) || i_ready;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req   (i_req_valid),
    .ptr   (ptr_reg),
    .en    (slot_free && !reset),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign o_req_ready = gnt;
  assign o_valid     = (state_reg == ST_FULL);
  assign a_sel       = i_req_a[int'(gnt_idx)*DATA_W +: DATA_W];
  assign b_sel       = i_req_b[int'(gnt_idx)*DATA_W +: DATA_W];
  assign diff        = {a_sel[DATA_W-1], a_sel} - {b_sel[DATA_W-1], b_sel};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
      ptr_reg   <= '0;
      o_c       <= '0;
      o_id      <= '0;
    end else if (gnt_any) begin
      state_reg <= ST_FULL;
      o_c       <= diff;
      o_id      <= gnt_idx;
      ptr_reg   <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (state_reg == ST_FULL && i_ready) begin
      state_reg <= ST_EMPTY;
    end
  end

`ifdef SUB_SHARE_STATS_EN
  logic [STAT_W-1:0] stall_cnt_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_grant_cnt
      logic [STAT_W-1:0] cnt_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg <= '0;
        end else if (gnt[gi] && cnt_reg != '1) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign o_grant_cnt[gi*STAT_W +: STAT_W] = cnt_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_reg <= '0;
    end else if (state_reg == ST_FULL && !i_ready && (|i_req_valid) && stall_cnt_reg != '1) begin
      stall_cnt_reg <= stall_cnt_reg + 1'b1;
    end
  end

  assign o_stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_sub_share_ctrl.sv
// Scoreboard bench for sub_share_ctrl: randomized requesters, queue-based reference model.
module tb_sub_share_ctrl;

  localparam int DATA_W = 24;
  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ*DATA_W-1:0] i_req_a;
  logic [N_REQ*DATA_W-1:0] i_req_b;
  logic [N_REQ-1:0]        o_req_ready;
  logic [DATA_W:0]         o_c;
  logic [ID_W-1:0]         o_id;
  logic                    o_valid;
  logic                    i_ready;
`ifdef SUB_SHARE_STATS_EN
  logic [N_REQ*16-1:0]     o_grant_cnt;
  logic [15:0]             o_stall_cnt;
`endif

  sub_share_ctrl #(.DATA_W(DATA_W), .N_REQ(N_REQ)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (i_req_valid),
    .i_req_a     (i_req_a),
    .i_req_b     (i_req_b),
    .o_req_ready (o_req_ready),
    .o_c         (o_c),
    .o_id        (o_id),
    .o_valid     (o_valid),
`ifdef SUB_SHARE_STATS_EN
    .o_grant_cnt (o_grant_cnt),
    .o_stall_cnt (o_stall_cnt),
`endif
    .i_ready     (i_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int c;
    int id;
  } res_t;

  res_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   ptr_m       = 0;
  bit   full_m      = 0;
  bit   exp_valid   = 0;
  bit   mon_en      = 0;
  bit   vv[N_REQ];
  int   va[N_REQ];
  int   vb[N_REQ];
  int   gcnt_m[N_REQ];
  int   stall_m     = 0;

  function automatic int rand_s24();
    logic signed [DATA_W-1:0] t;
    t = DATA_W'($urandom);
    return int'(t);
  endfunction

  // Offer new operands on idle requesters; pending ones keep their data.
  task automatic gen(input int pv);
    for (int i = 0; i < N_REQ; i++) begin
      if (!vv[i] && $urandom_range(99) < pv) begin
        vv[i] = 1'b1;
        va[i] = rand_s24();
        vb[i] = rand_s24();
      end
    end
  endtask

  // Drive one cycle, predict the grant, and update the reference model.
  task automatic step(input bit rdy, input bit rst);
    int k;
    int exp_ready;
    bit any_v;
    @(negedge clk);
    reset   = rst;
    i_ready = rdy;
    for (int i = 0; i < N_REQ; i++) begin
      i_req_valid[i]                 = vv[i];
      i_req_a[i*DATA_W +: DATA_W]    = DATA_W'(va[i]);
      i_req_b[i*DATA_W +: DATA_W]    = DATA_W'(vb[i]);
    end
    #1;
    exp_valid = full_m;
    any_v = 1'b0;
    for (int i = 0; i < N_REQ; i++) any_v |= vv[i];
    k = -1;
    if (!rst && (!full_m || rdy)) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (k < 0 && vv[(ptr_m + j) % N_REQ]) k = (ptr_m + j) % N_REQ;
      end
    end
    exp_ready = (k < 0) ? 0 : (1 << k);
    vectors++;
    if (int'(o_req_ready) != exp_ready) begin
      miscompares++;
      $display("FAIL ready: got %b want %b", o_req_ready, exp_ready[N_REQ-1:0]);
    end
    if (rst) begin
      q.delete();
      full_m = 0;
      ptr_m  = 0;
      stall_m = 0;
      for (int i = 0; i < N_REQ; i++) gcnt_m[i] = 0;
    end else begin
      if (full_m && !rdy && any_v && stall_m < 65535) stall_m++;
      if (k >= 0) begin
        q.push_back('{c: va[k] - vb[k], id: k});
        $display("grant id=%0d a=%0d b=%0d exp_c=%0d", k, va[k], vb[k], va[k] - vb[k]);
        full_m = 1;
        ptr_m  = (k + 1) % N_REQ;
        vv[k]  = 1'b0;
        if (gcnt_m[k] < 65535) gcnt_m[k]++;
      end else if (full_m && rdy) begin
        full_m = 0;
      end
    end
  endtask

  // Monitor: compare the presented result every valid cycle; pop on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en && !reset) begin
        vectors++;
        if (o_valid !== exp_valid) begin
          miscompares++;
          $display("FAIL valid: got %b want %b", o_valid, exp_valid);
        end
        if (o_valid) begin
          if (q.size() == 0) begin
            miscompares++;
            $display("FAIL result: got c=%0d id=%0d want nothing", $signed(o_c), o_id);
          end else begin
            vectors++;
            if (int'($signed(o_c)) != q[0].c || int'(o_id) != q[0].id) begin
              miscompares++;
              $display("FAIL result: got c=%0d id=%0d want c=%0d id=%0d",
                       $signed(o_c), o_id, q[0].c, q[0].id);
            end
            if (i_ready) void'(q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    i_ready     = 1'b0;
    i_req_valid = '0;
    i_req_a     = '0;
    i_req_b     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      vv[i] = 0; va[i] = 0; vb[i] = 0; gcnt_m[i] = 0;
    end
    repeat (3) step(1'b1, 1'b1);
    @(negedge clk);
    vectors++;
    if (o_c !== '0 || o_id !== '0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got c=%0d id=%0d v=%b want 0 0 0", o_c, o_id, o_valid);
    end
    mon_en = 1'b1;

    // Single request, then the signed extremes.
    vv[0] = 1; va[0] = 100; vb[0] = 250;
    step(1'b1, 1'b0);
    vv[1] = 1; va[1] = -8388608; vb[1] = 8388607;
    step(1'b1, 1'b0);
    vv[2] = 1; va[2] = 8388607; vb[2] = -8388608;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // All requesters continuously valid with the consumer always ready.
    for (int n = 0; n < 16; n++) begin
      gen(100);
      step(1'b1, 1'b0);
    end

    // Backpressure with requesters 1 and 3 waiting.
    vv[1] = 1; va[1] = rand_s24(); vb[1] = rand_s24();
    vv[3] = 1; va[3] = rand_s24(); vb[3] = rand_s24();
    repeat (5) step(1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0);

    // Reset while full with requests 0 and 2 pending, then release.
    vv[0] = 1; va[0] = rand_s24(); vb[0] = rand_s24();
    vv[2] = 1; va[2] = rand_s24(); vb[2] = rand_s24();
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);

    // Random traffic with random backpressure and occasional reset.
    for (int n = 0; n < 2000; n++) begin
      gen($urandom_range(100));
      step($urandom_range(3) != 0, $urandom_range(199) == 0);
    end

    for (int i = 0; i < N_REQ; i++) vv[i] = 0;
    repeat (4) step(1'b1, 1'b0);
    @(negedge clk);
    vectors++;
    if (q.size() != 0 || o_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: got pending=%0d valid=%b want 0 0", q.size(), o_valid);
    end
`ifdef SUB_SHARE_STATS_EN
    for (int i = 0; i < N_REQ; i++) begin
      vectors++;
      if (int'(o_grant_cnt[i*16 +: 16]) != gcnt_m[i]) begin
        miscompares++;
        $display("FAIL grant_cnt[%0d]: got %0d want %0d", i, o_grant_cnt[i*16 +: 16], gcnt_m[i]);
      end
    end
    vectors++;
    if (int'(o_stall_cnt) != stall_m) begin
      miscompares++;
      $display("FAIL stall_cnt: got %0d want %0d", o_stall_cnt, stall_m);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sub_share_ctrl.md
# sub_share_ctrl

Round-robin scheduler that time-shares one registered subtractor (A − B, DATA_W+1-bit signed result) among N_REQ requesters in the demodulator datapath. Each requester presents an operand pair with valid/ready. The block grants one requester per cycle and returns the difference on a single tagged output bus to one downstream consumer. It sits between the per-branch stages (I/Q or per-channel) and the shared difference consumer, replacing N private subtractors.

## Interface
Parameters:
- DATA_W, 24, operand width (signed)
- N_REQ, 4, number of requesters (≥1)

Ports:
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- i_req_valid  in  N_REQ  per-requester operand pair valid
- i_req_a  in  N_REQ×DATA_W  per-requester minuend, signed
- i_req_b  in  N_REQ×DATA_W  per-requester subtrahend, signed
- o_req_ready  out  N_REQ  one-hot (or zero) grant/accept, combinational
- o_c  out  DATA_W+1  signed difference a − b of granted requester
- o_id  out  ID_W  index of requester that produced o_c
- o_valid  out  1  o_c/o_id valid
- i_ready  in  1  consumer accepts o_c this cycle

## Operation
- Output register state: EMPTY (o_valid=0) or FULL (o_valid=1).
- Slot is "free" when EMPTY, or when FULL and i_ready=1 (drain and refill in the same cycle).
- If the slot is free and any i_req_valid is set, the block grants one requester k by round-robin:
  - Search starts at pointer rr_ptr and goes upward with wrap N_REQ−1 → 0.
  - o_req_ready[k]=1 combinationally; all other bits are 0.
- On a grant edge:
  - o_c <= sign-extend(a_k) − sign-extend(b_k), computed in DATA_W+1 bits; no overflow is possible.
  - o_id <= k; state <= FULL.
  - rr_ptr <= (k+1) mod N_REQ.
- FULL with i_ready=0: o_c, o_id and o_valid hold; o_req_ready=0.
- FULL with i_ready=1 and no request pending: state <= EMPTY, o_valid falls. o_c/o_id hold their stale values.
- If the slot is not free or no request is pending, o_req_ready is all-zero and rr_ptr holds.
- Requester rule: a_k/b_k are held stable while i_req_valid[k]=1 and o_req_ready[k]=0. The block does not latch unaccepted operands.
- Fairness: a continuously-valid requester is granted within N_REQ grants.
- N_REQ=1: ID_W=1, o_id always 0, pointer constant 0.

## Timing
- Reset values: o_c=0, o_id=0, o_valid=0, state=EMPTY, rr_ptr=0. o_req_ready=0 during reset.
- Latency: operands accepted at edge t appear on o_c with o_valid=1 in the cycle after edge t (1 cycle).
- Throughput: 1 result/cycle when i_ready is held high.
- o_req_ready depends combinationally on i_req_valid, i_ready, state and rr_ptr. There is no path from i_req_a/i_req_b to any ready signal.
- Reset asserted mid-transfer:
  - A pending FULL result is discarded.
  - Any grant in that cycle is suppressed.
  - The first grant after release goes to the lowest valid index ≥0.

## Configuration
- SUB_SHARE_STATS_EN defined adds statistics outputs:
  - o_grant_cnt (N_REQ×16, out): per-requester accepted-grant counters.
  - o_stall_cnt (16, out): cycles with FULL && !i_ready && any request valid.
  - All counters saturate at 0xFFFF and clear on reset.
- Not defined: these ports and counters are absent; the core behaviour is identical.

## Structure
- Package sub_share_pkg holds:
  - ID_W = (N_REQ>1) ? $clog2(N_REQ) : 1, as a localparam function.
  - Output state enum {ST_EMPTY, ST_FULL}.
  - Stats counter width constant STAT_W=16.
- Sub-module rr_arbiter (parameter N):
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant, grant index, any-grant flag.
  - Purely combinational.
- Top level holds the pointer register, output register, state and optional stats.

## Test plan
- Reset then single request: i_req_valid=0001, a[0]=100, b[0]=250, i_ready=1 → o_req_ready=0001 that cycle; next cycle o_valid=1, o_c=−150, o_id=0.
- Extremes, DATA_W=24: a=−8388608, b=8388607 → o_c=−16777215; a=8388607, b=−8388608 → o_c=16777215 (25-bit, no wrap).
- All four valid continuously, i_ready=1 → o_id sequence 0,1,2,3,0,1… with o_valid high every cycle; each o_req_ready pulse lasts one cycle.
- Backpressure: FULL with o_id=2, i_ready=0 for 5 cycles, requests 1 and 3 valid → o_c/o_id stable and o_req_ready=0000 throughout. On the first i_ready=1 cycle, o_req_ready=1000 (pointer at 3) and the new result loads the next cycle with no bubble.
- Reset mid-stream: assert reset while FULL and requests 0 and 2 valid → next cycle o_valid=0 and ready=0000. After release, the first grant goes to requester 0.
- With SUB_SHARE_STATS_EN: 70000 grants to requester 1 → o_grant_cnt[1]=0xFFFF saturated, other counters unchanged.
